// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: start/done-controlled exhaustive sweep of an external adder.
// Define ADDER_SWEEP_FIRST_FAIL_EN to build the first-failing-vector capture registers.
`default_nettype none

module adder_sweep_checker #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 c_in_out,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 c_out_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH+1:0]   err_count,
  output logic                 first_fail_valid,
  output logic [2*WIDTH:0]     first_fail_vec
);

  localparam int VW = 2 * WIDTH + 1;
  localparam logic [VW-1:0] LAST_VEC = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [VW-1:0]   r_vec;
  logic [VW:0]     r_err;
  logic [WIDTH:0]  w_expected;
  logic            w_mismatch;

  // Vector layout is {c_in, a, b}, so the sweep walks b fastest.
  always_comb begin
    w_expected = {1'b0, r_vec[WIDTH-1:0]}
               + {1'b0, r_vec[2*WIDTH-1:WIDTH]}
               + {{WIDTH{1'b0}}, r_vec[VW-1]};
    w_mismatch = ({c_out_in, sum_in} != w_expected);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_vec == LAST_VEC) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The counter wraps to zero on the last compare, returning the driven operands to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
      r_err <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec <= '0;
            r_err <= '0;
          end
        end
        RUN: begin
          r_vec <= r_vec + 1'b1;
          if (w_mismatch) r_err <= r_err + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_SWEEP_FIRST_FAIL_EN
  logic          r_ff_valid;
  logic [VW-1:0] r_ff_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (r_state == IDLE && start) begin
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else if (r_state == RUN && w_mismatch && !r_ff_valid) begin
      r_ff_valid <= 1'b1;
      r_ff_vec   <= r_vec;
    end
  end

  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_vec   = '0;
`endif

  assign c_in_out  = r_vec[VW-1];
  assign a_out     = r_vec[2*WIDTH-1:WIDTH];
  assign b_out     = r_vec[WIDTH-1:0];
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: directed test of the adder sweep checker with injectable adder faults.
`default_nettype none

module tb_adder_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  a_out, b_out, sum_in;
  logic        c_in_out, c_out_in, busy, done, ffv;
  logic [9:0]  err_count;
  logic [8:0]  ffvec;

  logic        start2 = 1'b0;
  logic [1:0]  a2, b2, sum2;
  logic        cin2, cout2, busy2, done2, ffv2;
  logic [5:0]  err2;
  logic [4:0]  ffvec2;

  int fault = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Adder model with fault injection: 1 = sum[0] stuck-at-0, 2 = c_out stuck-at-0.
  logic [4:0] full4;
  logic [2:0] full2;
  always_comb begin
    full4 = {1'b0, a_out} + {1'b0, b_out} + {4'b0, c_in_out};
    sum_in = full4[3:0];
    c_out_in = full4[4];
    if (fault == 1) sum_in[0] = 1'b0;
    if (fault == 2) c_out_in = 1'b0;
    full2 = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
    sum2 = full2[1:0] & 2'b10;
    cout2 = full2[2];
  end

  adder_sweep_checker #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .c_in_out(c_in_out),
    .sum_in(sum_in), .c_out_in(c_out_in),
    .busy(busy), .done(done), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  adder_sweep_checker #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a_out(a2), .b_out(b2), .c_in_out(cin2),
    .sum_in(sum2), .c_out_in(cout2),
    .busy(busy2), .done(done2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sweep; optionally pulses start again rep_at cycles after the start edge.
  task automatic sweep(input int rep_at, output int lat, output int pulses);
    int e0;
    int d0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    d0 = done_cnt;
    chk("busy_after_start", {31'b0, busy}, 1);
    lat = -1;
    for (int k = 1; k <= 1100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      start = (k == rep_at);
      if (k == 37) chk("vector_37", {23'b0, c_in_out, a_out, b_out}, 37);
      if (done) begin
        lat = cyc - e0;
        chk("busy_low_at_done", {31'b0, busy}, 0);
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("operands_zero_after", {23'b0, c_in_out, a_out, b_out}, 0);
    pulses = done_cnt - d0;
  endtask

  typedef struct {
    int         flt;
    int         exp_err;
    logic       exp_ffv;
    logic [8:0] exp_vec;
  } vec_t;

  vec_t tbl[3];
  int lat;
  int pulses;
  int d0;
  int e0;

  initial begin
    tbl[0] = '{0, 0, 1'b0, 9'd0};
    tbl[1] = '{1, 256, 1'b1, 9'b0_0000_0001};
    tbl[2] = '{2, 256, 1'b1, 9'b0_0001_1111};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_err", {22'b0, err_count}, 0);
    chk("reset_ops", {23'b0, c_in_out, a_out, b_out}, 0);
    chk("reset_ffv", {31'b0, ffv}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      fault = tbl[i].flt;
      sweep(0, lat, pulses);
      chk("latency", lat, 512);
      chk("done_pulses", pulses, 1);
      chk("err_count", {22'b0, err_count}, tbl[i].exp_err);
`ifdef ADDER_SWEEP_FIRST_FAIL_EN
      chk("ff_valid", {31'b0, ffv}, {31'b0, tbl[i].exp_ffv});
      chk("ff_vec", {23'b0, ffvec}, {23'b0, tbl[i].exp_vec});
`else
      chk("ff_valid", {31'b0, ffv}, 0);
      chk("ff_vec", {23'b0, ffvec}, 0);
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("err_holds_idle", {22'b0, err_count}, tbl[i].exp_err);
    end

    // start re-pulsed mid-sweep is ignored
    fault = 1;
    sweep(100, lat, pulses);
    chk("repulse_latency", lat, 512);
    chk("repulse_pulses", pulses, 1);
    chk("repulse_err", {22'b0, err_count}, 256);

    // reset mid-sweep aborts with no done pulse
    fault = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(posedge clk);
    #3;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ops", {23'b0, c_in_out, a_out, b_out}, 0);
    chk("abort_err", {22'b0, err_count}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, lat, pulses);
    chk("post_reset_latency", lat, 512);
    chk("post_reset_err", {22'b0, err_count}, 0);

    // start held high: back-to-back sweeps with one IDLE cycle between
    @(negedge clk);
    start = 1'b1;
    lat = -1;
    for (int k = 0; k < 1100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    if (lat < 0) chk("b2b_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("b2b_idle_gap", {31'b0, busy}, 0);
    @(posedge clk);
    #1;
    chk("b2b_restart", {31'b0, busy}, 1);
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 1100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    if (lat < 0) chk("b2b_end_timeout", 0, 1);

    // WIDTH=2 instance with sum[0] stuck-at-0
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start2 = 1'b0;
    lat = -1;
    for (int k = 0; k < 100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (done2) lat = cyc - e0;
    end
    chk("w2_latency", lat, 32);
    chk("w2_err", {26'b0, err2}, 16);
`ifdef ADDER_SWEEP_FIRST_FAIL_EN
    chk("w2_ffv", {31'b0, ffv2}, 1);
    chk("w2_ffvec", {27'b0, ffvec2}, 1);
`else
    chk("w2_ffv", {31'b0, ffv2}, 0);
    chk("w2_ffvec", {27'b0, ffvec2}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Built-in self-test stage that wraps a combinational ripple-carry adder. It drives every `{c_in, a, b}` combination into the adder in sequence. Each cycle it compares the adder's `sum`/`c_out` against an internal golden sum, then reports an error count and the first failing vector. It replaces the free-running simulation sweep with a synthesizable, start/done-controlled checker that can run on the board.

## Interface
- `WIDTH`, default 4: operand width of the adder under test; the sweep covers 2^(2·WIDTH+1) vectors.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `start`  input  1: begins a sweep when sampled high in IDLE.
- `a_out`  output  WIDTH: operand a driven to the adder.
- `b_out`  output  WIDTH: operand b driven to the adder.
- `c_in_out`  output  1: carry-in driven to the adder.
- `sum_in`  input  WIDTH: adder sum, combinational from a_out/b_out/c_in_out.
- `c_out_in`  input  1: adder carry-out.
- `busy`  output  1: high while in RUN.
- `done`  output  1: one-cycle pulse at sweep completion.
- `err_count`  output  2·WIDTH+2: number of mismatching vectors in the last sweep.
- `first_fail_valid`  output  1: a mismatch was recorded in the last sweep.
- `first_fail_vec`  output  2·WIDTH+1: `{c_in, a, b}` of the first mismatch.

## Operation
- State machine states are IDLE, RUN and DONE; reset enters IDLE.
- IDLE → RUN when `start`=1.
  - On that edge: clear `err_count`, `first_fail_valid` and `first_fail_vec`.
  - Load vector counter v = 0.
- RUN:
  - `{c_in_out, a_out, b_out}` = v, driven from registers.
  - On each edge:
    - Compute expected = a_out + b_out + c_in_out at WIDTH+1 bits, unsigned.
    - Mismatch if `{c_out_in, sum_in}` ≠ expected.
    - On mismatch, `err_count` increments.
    - If `first_fail_valid`=0 on a mismatch, latch v into `first_fail_vec` and set `first_fail_valid`.
  - Then v increments.
- RUN → DONE on the edge that compares v = 2^(2·WIDTH+1)−1.
  - v wraps to 0 and the driven outputs return to 0.
- DONE: `done`=1 for one cycle, then → IDLE unconditionally.
- `start` in RUN or DONE is ignored; there is no restart mid-sweep.
- Results hold in IDLE until the next accepted `start`.
- `err_count` width fits the maximum of 2^(2·WIDTH+1) errors, so no saturation is needed.

## Timing
- Reset values, applied asynchronously on `rst_n`=0:
  - state = IDLE.
  - `a_out`, `b_out`, `c_in_out`, `busy`, `done`, `err_count`, `first_fail_valid`, `first_fail_vec` are all 0.
- Reset mid-sweep aborts immediately; no `done` pulse is produced.
- `start` sampled at edge E0 → `busy` high after E0.
  - Vector k is driven after E0+k and compared at E0+k+1.
  - `busy` falls and `done` rises after E0+2^(2·WIDTH+1).
  - `done` falls after the next edge.
- With WIDTH=4: 512 compare cycles; `done` rises 512 cycles after the start edge.
- The adder must settle within one clock period, since its response is sampled at the edge after it is driven.
- `start` held high continuously gives back-to-back sweeps, with one IDLE cycle between them.

## Configuration
- `ADDER_SWEEP_FIRST_FAIL_EN` defined:
  - first-fail capture logic is compiled in, as described above.
- `ADDER_SWEEP_FIRST_FAIL_EN` undefined:
  - no capture registers are built.
  - `first_fail_valid` and `first_fail_vec` are tied to 0.
  - `err_count`, `busy` and `done` are unchanged.

## Test plan
- Correct adder model (WIDTH=4), `start` pulse → `done` rises 512 cycles after the start edge; `err_count`=0; `first_fail_valid`=0.
- Adder with `sum[0]` stuck-at-0 → `err_count`=256; `first_fail_vec`=9'b0_0000_0001.
- Adder with `c_out` stuck-at-0 → `err_count`=256 (vectors with a+b+c_in ≥ 16); `first_fail_vec`=9'b0_0001_1111 (a=1, b=15).
- `start` re-pulsed at vector 100 → ignored; the sweep still ends at 512 cycles with a single `done`.
- `rst_n` low at vector 100 → all outputs 0 immediately with no `done`; a new `start` completes a full 512-cycle sweep.
- WIDTH=2 with the `sum[0]` fault and `ADDER_SWEEP_FIRST_FAIL_EN` undefined → `done` after 32 cycles; `err_count`=16; first_fail outputs 0.
